// File: rtl/zimbo_isa_pkg.sv
`default_nettype none
// ============================================================================
// Module   : zimbo_isa_pkg
// Purpose  : Shared ISA definitions for the instruction-side fetch/issue unit:
//            opcode constants, instruction field bit positions and the fetch
//            state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package zimbo_isa_pkg;

  // Opcode constants (ir[15:11])
  localparam logic [4:0] OP_NOP      = 5'b00000;
  localparam logic [4:0] OP_HLT      = 5'b11111;
  localparam logic [4:0] OP_BEQ      = 5'b10100;
  localparam logic [4:0] OP_BNE      = 5'b10101;
  localparam logic [4:0] OP_BLT      = 5'b10110;
  // Jumps are any opcode matching 110xx
  localparam logic [4:0] OP_JMP_PAT  = 5'b11000;
  localparam logic [4:0] OP_JMP_MASK = 5'b11100;

  // Instruction field bit positions
  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 11;
  localparam int unsigned RD_MSB  = 10;
  localparam int unsigned RD_LSB  = 8;
  localparam int unsigned IMM_MSB = 7;
  localparam int unsigned IMM_LSB = 0;
  localparam int unsigned FN_MSB  = 2;
  localparam int unsigned FN_LSB  = 0;

  // Fetch state encoding
  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_WAIT      = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_HALTED    = 3'd3,
    ST_STEP_WAIT = 3'd4
  } fetch_state_e;

  function automatic logic is_jmp(input logic [4:0] op);
    return (op & OP_JMP_MASK) == OP_JMP_PAT;
  endfunction

endpackage
`default_nettype wire

// File: rtl/next_pc_sel.sv
`default_nettype none
// ============================================================================
// Module   : next_pc_sel
// Purpose  : Combinational next-PC selection. Priority: jump (zero-extended
//            imm8), then branch (pc + sign-extended imm8, modulo 2^AW), then
//            pc + 1 (wrapping).
// Ports    : i_pc      - current PC
//            i_imm8    - 8-bit immediate from the instruction
//            i_jump    - take jump
//            i_branch  - take branch
//            o_next_pc - selected next PC
// Revision : 1.0 - initial release
// ============================================================================
module next_pc_sel #(
  parameter int AW = 8
) (
  input  logic [AW-1:0] i_pc,
  input  logic [7:0]    i_imm8,
  input  logic          i_jump,
  input  logic          i_branch,
  output logic [AW-1:0] o_next_pc
);

  logic [AW-1:0] w_zext;
  logic [AW-1:0] w_sext;

  // Fit the 8-bit immediate to the PC width; replication counts of zero are
  // avoided by splitting on AW.
  generate
    if (AW > 8) begin : g_wide
      assign w_zext = {{(AW-8){1'b0}}, i_imm8};
      assign w_sext = {{(AW-8){i_imm8[7]}}, i_imm8};
    end else if (AW == 8) begin : g_exact
      assign w_zext = i_imm8;
      assign w_sext = i_imm8;
    end else begin : g_narrow
      assign w_zext = i_imm8[AW-1:0];
      assign w_sext = i_imm8[AW-1:0];
    end
  endgenerate

  always_comb begin
    o_next_pc = i_pc + AW'(1);
    if (i_jump) begin
      o_next_pc = w_zext;
    end else if (i_branch) begin
      o_next_pc = i_pc + w_sext;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_issue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_issue
// Purpose  : Instruction fetch/issue unit. Owns the PC, fetches 16-bit words
//            from synchronous memory into the instruction register, presents
//            decoded fields to control, holds them across multi-cycle ops,
//            computes the next PC, detects HLT and counts retirements.
//            Optional macro FETCH_STEP_EN adds a single-step wait state
//            (STEP_WAIT) after every retire, released by step_exe.
// Ports    : clock/reset            - clock, synchronous active-high reset
//            mem_addr/mem_rd_req    - fetch address and read strobe
//            mem_rdata              - read data, valid one cycle after strobe
//            pc_en/ctrl_more        - retire = pc_en & ~ctrl_more in ISSUE
//            jump/branch            - next-PC selection controls
//            step_exe               - single-step pulse (FETCH_STEP_EN only)
//            opcode/func/rdest/imm8 - instruction register fields
//            instr                  - full instruction register
//            ins_valid/halted       - ISSUE / HALTED status
//            pc/retire_cnt          - current PC, retired-instruction count
// Revision : 1.0 - initial release
// ============================================================================
module fetch_issue
  import zimbo_isa_pkg::*;
#(
  parameter int            AW       = 8,
  parameter int            IW       = 16,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clock,
  input  logic          reset,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd_req,
  input  logic [IW-1:0] mem_rdata,
  input  logic          pc_en,
  input  logic          ctrl_more,
  input  logic          jump,
  input  logic          branch,
  input  logic          step_exe,
  output logic [4:0]    opcode,
  output logic [2:0]    func,
  output logic [2:0]    rdest,
  output logic [7:0]    imm8,
  output logic [IW-1:0] instr,
  output logic          ins_valid,
  output logic [AW-1:0] pc,
  output logic          halted,
  output logic [15:0]   retire_cnt
);

  fetch_state_e  r_state;
  fetch_state_e  w_next_state;
  logic [AW-1:0] r_pc;
  logic [IW-1:0] r_ir;
  logic [15:0]   r_retire_cnt;
  logic [AW-1:0] w_next_pc;
  logic          w_retire;

`ifndef FETCH_STEP_EN
  logic w_unused_step;
  assign w_unused_step = step_exe;
`endif

  assign w_retire = (r_state == ST_ISSUE) && pc_en && !ctrl_more;

  next_pc_sel #(
    .AW (AW)
  ) u_next_pc_sel (
    .i_pc      (r_pc),
    .i_imm8    (r_ir[IMM_MSB:IMM_LSB]),
    .i_jump    (jump),
    .i_branch  (branch),
    .o_next_pc (w_next_pc)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_FETCH;
      r_pc         <= RESET_PC;
      r_ir         <= '0;
      r_retire_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_WAIT) begin
        r_ir <= mem_rdata;
      end
      if (w_retire) begin
        r_pc         <= w_next_pc;
        r_retire_cnt <= r_retire_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_FETCH: w_next_state = ST_WAIT;
      ST_WAIT:  w_next_state = ST_ISSUE;
      ST_ISSUE: begin
        if (w_retire) begin
`ifdef FETCH_STEP_EN
          w_next_state = ST_STEP_WAIT;
`else
          w_next_state = ST_FETCH;
`endif
        end else if (r_ir[OPC_MSB:OPC_LSB] == OP_HLT) begin
          w_next_state = ST_HALTED;
        end
      end
      ST_HALTED: w_next_state = ST_HALTED;
`ifdef FETCH_STEP_EN
      // Only a pulse seen while already waiting releases the step.
      ST_STEP_WAIT: begin
        if (step_exe) begin
          w_next_state = ST_FETCH;
        end
      end
`endif
      default: w_next_state = ST_FETCH;
    endcase
  end

  // Status strobes are forced low while reset is held so the reset values
  // are visible before the first clock edge of reset is even applied.
  assign mem_addr   = r_pc;
  assign mem_rd_req = (r_state == ST_FETCH) && !reset;
  assign ins_valid  = (r_state == ST_ISSUE) && !reset;
  assign halted     = (r_state == ST_HALTED) && !reset;
  assign pc         = r_pc;
  assign retire_cnt = r_retire_cnt;
  assign instr      = r_ir;
  assign opcode     = r_ir[OPC_MSB:OPC_LSB];
  assign rdest      = r_ir[RD_MSB:RD_LSB];
  assign imm8       = r_ir[IMM_MSB:IMM_LSB];
  assign func       = r_ir[FN_MSB:FN_LSB];

endmodule
`default_nettype wire
